// File: rtl/scalar_operand_fetch.sv
// Scalar operand-fetch stage: per-register busy scoreboard, RAW/WAW stall,
// same-cycle writeback forwarding and a one-entry valid/ready output register.
module scalar_operand_fetch #(
    parameter int DATA_W = 32,
    parameter int NREG   = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_op,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              in_use_rs1,
    input  logic              in_use_rs2,
    input  logic              in_writes_rd,
    output logic [ADDR_W-1:0] rf_rs1,
    output logic [ADDR_W-1:0] rf_rs2,
    input  logic [DATA_W-1:0] rf_ro1,
    input  logic [DATA_W-1:0] rf_ro2,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [5:0]        out_op,
    output logic [ADDR_W-1:0] out_rd,
    output logic              out_writes_rd,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [15:0]       stall_count
);

    logic [NREG-1:0]   r_busy;
    logic              r_out_valid;
    logic [5:0]        r_out_op;
    logic [ADDR_W-1:0] r_out_rd;
    logic              r_out_writes_rd;
    logic [DATA_W-1:0] r_out_a;
    logic [DATA_W-1:0] r_out_b;
    logic [15:0]       r_stall_count;

    logic              w_fwd1;
    logic              w_fwd2;
    logic              w_fwd_d;
    logic              w_raw1;
    logic              w_raw2;
    logic              w_waw;
    logic              w_hazard;
    logic              w_accept;
    logic [NREG-1:0]   w_busy_next;

    assign rf_rs1 = in_rs1;
    assign rf_rs2 = in_rs2;

    assign w_fwd1  = wb_valid && (wb_rd == in_rs1);
    assign w_fwd2  = wb_valid && (wb_rd == in_rs2);
    assign w_fwd_d = wb_valid && (wb_rd == in_rd);

    assign w_raw1   = in_use_rs1   && r_busy[in_rs1] && !w_fwd1;
    assign w_raw2   = in_use_rs2   && r_busy[in_rs2] && !w_fwd2;
    assign w_waw    = in_writes_rd && r_busy[in_rd]  && !w_fwd_d;
    assign w_hazard = w_raw1 || w_raw2 || w_waw;

    assign in_ready = (!r_out_valid || out_ready) && !w_hazard;
    assign w_accept = in_valid && in_ready;

    always_comb begin
        // NOTE: default assigned first so every path drives w_busy_next and no latch is inferred.
        w_busy_next = r_busy;
        if (wb_valid) begin
            w_busy_next[wb_rd] = 1'b0;
        end
        // Set after clear: a writer issued alongside the writeback keeps the register busy.
        if (w_accept && in_writes_rd) begin
            w_busy_next[in_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_busy          <= '0;
            r_out_valid     <= 1'b0;
            r_out_op        <= '0;
            r_out_rd        <= '0;
            r_out_writes_rd <= 1'b0;
            r_out_a         <= '0;
            r_out_b         <= '0;
            r_stall_count   <= '0;
        end else begin
            r_busy <= w_busy_next;

            if (w_accept) begin
                r_out_valid     <= 1'b1;
                r_out_op        <= in_op;
                r_out_rd        <= in_rd;
                r_out_writes_rd <= in_writes_rd;
                r_out_a         <= w_fwd1 ? wb_data : rf_ro1;
                r_out_b         <= w_fwd2 ? wb_data : rf_ro2;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (in_valid && w_hazard && (r_stall_count != 16'hFFFF)) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
        end
    end

    assign out_valid     = r_out_valid;
    assign out_op        = r_out_op;
    assign out_rd        = r_out_rd;
    assign out_writes_rd = r_out_writes_rd;
    assign out_a         = r_out_a;
    assign out_b         = r_out_b;
    assign stall_count   = r_stall_count;

endmodule

// File: tb/tb_scalar_operand_fetch.sv
// Bench for scalar_operand_fetch: behavioural register bank plus a queue of
// expected execute-side transfers, popped whenever out_valid && out_ready.
`timescale 1ns/1ps
module tb_scalar_operand_fetch;

    localparam int DATA_W = 32;
    localparam int NREG   = 8;
    localparam int ADDR_W = 3;

    typedef struct {
        logic [5:0]        op;
        logic [ADDR_W-1:0] rd;
        logic              wr;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [5:0]        in_op;
    logic [ADDR_W-1:0] in_rs1, in_rs2, in_rd;
    logic              in_use_rs1, in_use_rs2, in_writes_rd;
    logic [ADDR_W-1:0] rf_rs1, rf_rs2;
    logic [DATA_W-1:0] rf_ro1, rf_ro2;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [5:0]        out_op;
    logic [ADDR_W-1:0] out_rd;
    logic              out_writes_rd;
    logic [DATA_W-1:0] out_a, out_b;
    logic [15:0]       stall_count;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t sb[$];

    logic [DATA_W-1:0] bank [NREG];

    scalar_operand_fetch #(.DATA_W(DATA_W), .NREG(NREG), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2), .in_writes_rd(in_writes_rd),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_ro1(rf_ro1), .rf_ro2(rf_ro2),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_rd(out_rd),
        .out_writes_rd(out_writes_rd), .out_a(out_a), .out_b(out_b),
        .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register bank: r2=5, r3=7, others tagged by index; written on the wb edge.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                bank[i] <= (i == 2) ? 32'd5 : (i == 3) ? 32'd7 : 32'h1000_0000 + 32'(i);
        end else if (wb_valid) begin
            bank[wb_rd] <= wb_data;
        end
    end
    assign rf_ro1 = bank[rf_rs1];
    assign rf_ro2 = bank[rf_rs2];

    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL sb_unexpected: transfer op=%h a=%h b=%h, required none", out_op, out_a, out_b);
            end else begin
                e = sb.pop_front();
                if ({out_op, out_rd, out_writes_rd, out_a, out_b} !== {e.op, e.rd, e.wr, e.a, e.b}) begin
                    miscompares++;
                    $display("FAIL sb_transfer: got op=%h rd=%0d wr=%b a=%h b=%h, required op=%h rd=%0d wr=%b a=%h b=%h",
                             out_op, out_rd, out_writes_rd, out_a, out_b, e.op, e.rd, e.wr, e.a, e.b);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic set_instr(input logic v, input logic [5:0] op, input logic [2:0] rs1,
                             input logic [2:0] rs2, input logic [2:0] rd,
                             input logic u1, input logic u2, input logic wr);
        in_valid = v; in_op = op; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
        in_use_rs1 = u1; in_use_rs2 = u2; in_writes_rd = wr;
    endtask

    task automatic wb_drive(input logic v, input logic [2:0] rd, input logic [31:0] d);
        wb_valid = v; wb_rd = rd; wb_data = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.op = in_op;
        e.rd = in_rd;
        e.wr = in_writes_rd;
        e.a  = (wb_valid && wb_rd == in_rs1) ? wb_data : bank[in_rs1];
        e.b  = (wb_valid && wb_rd == in_rs2) ? wb_data : bank[in_rs2];
        return e;
    endfunction

    task automatic test_reset();
        rst = 1'b1; out_ready = 1'b1;
        wb_drive(1'b0, 3'd0, 32'd0);
        set_instr(1'b1, 6'h3F, 3'd1, 3'd2, 3'd6, 1'b1, 1'b1, 1'b1);
        repeat (2) next_cycle();
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++; $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
        next_cycle();
        rst = 1'b0;
        set_instr(1'b0, 6'h00, 3'd6, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        vectors++;
        if ({out_valid, out_op, out_rd, out_writes_rd, out_a, out_b, stall_count} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got v=%b op=%h rd=%0d wr=%b a=%h b=%h stall=%0d, required all zero",
                     out_valid, out_op, out_rd, out_writes_rd, out_a, out_b, stall_count);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++; $display("FAIL reset_no_accept: in_ready=%b, required 1 (r6 must not be busy)", in_ready);
        end
        next_cycle();
    endtask

    task automatic test_basic();
        set_instr(1'b1, 6'h11, 3'd2, 3'd3, 3'd4, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++; $display("FAIL basic_in_ready: got %b, required 1", in_ready);
        end
        next_cycle();
        sb.push_back('{6'h11, 3'd4, 1'b1, 32'd5, 32'd7});
        set_instr(1'b0, 6'h00, 3'd4, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++; $display("FAIL basic_out_valid: got %b, required 1", out_valid);
        end
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++; $display("FAIL basic_busy4: in_ready=%b, required 0", in_ready);
        end
        vectors++;
        if (stall_count !== 16'd0) begin
            miscompares++; $display("FAIL basic_stall_idle: got %0d, required 0", stall_count);
        end
        next_cycle();
    endtask

    task automatic test_raw_forward();
        exp_t e;
        set_instr(1'b1, 6'h22, 3'd4, 3'd2, 3'd5, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (in_ready !== 1'b0) begin
                miscompares++; $display("FAIL raw_stall[%0d]: in_ready=%b, required 0", i, in_ready);
            end
            next_cycle();
        end
        wb_drive(1'b1, 3'd4, 32'hDEAD_BEEF);
        @(negedge clk);
        vectors++;
        if (stall_count !== 16'd3) begin
            miscompares++; $display("FAIL raw_stall_count: got %0d, required 3", stall_count);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++; $display("FAIL raw_fwd_accept: in_ready=%b, required 1", in_ready);
        end
        next_cycle();
        sb.push_back('{6'h22, 3'd5, 1'b1, 32'hDEAD_BEEF, 32'd5});
        wb_drive(1'b0, 3'd0, 32'd0);
        set_instr(1'b1, 6'h23, 3'd4, 3'd4, 3'd0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++; $display("FAIL raw_after_wb: in_ready=%b, required 1", in_ready);
        end
        next_cycle();
        sb.push_back('{6'h23, 3'd0, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF});
        set_instr(1'b0, 6'h00, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_waw();
        exp_t e;
        set_instr(1'b1, 6'h31, 3'd6, 3'd7, 3'd1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        e = model_out();
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++; $display("FAIL waw_first: in_ready=%b, required 1", in_ready);
        end
        next_cycle();
        sb.push_back(e);
        set_instr(1'b1, 6'h32, 3'd2, 3'd3, 3'd1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vectors++;
            if (in_ready !== 1'b0) begin
                miscompares++; $display("FAIL waw_stall[%0d]: in_ready=%b, required 0", i, in_ready);
            end
            next_cycle();
        end
        wb_drive(1'b1, 3'd1, 32'hA5A5_0001);
        @(negedge clk);
        e = model_out();
        vectors++;
        if (in_ready !== 1'b1 || stall_count !== 16'd5) begin
            miscompares++;
            $display("FAIL waw_accept: in_ready=%b stall=%0d, required 1 and 5", in_ready, stall_count);
        end
        next_cycle();
        sb.push_back(e);
        wb_drive(1'b0, 3'd0, 32'd0);
        set_instr(1'b0, 6'h00, 3'd0, 3'd0, 3'd1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++; $display("FAIL waw_busy_kept: in_ready=%b, required 0", in_ready);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        exp_t ea, eb, ec;
        out_ready = 1'b0;
        set_instr(1'b1, 6'h41, 3'd2, 3'd3, 3'd6, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        ea = model_out();
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++; $display("FAIL bp_first: in_ready=%b, required 1", in_ready);
        end
        next_cycle();
        sb.push_back(ea);
        set_instr(1'b1, 6'h42, 3'd3, 3'd2, 3'd7, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (i == 0) wb_drive(1'b1, 3'd5, 32'h5555_AAAA);
            else        wb_drive(1'b0, 3'd0, 32'd0);
            @(negedge clk);
            vectors++;
            if (in_ready !== 1'b0) begin
                miscompares++; $display("FAIL bp_in_ready[%0d]: got %b, required 0", i, in_ready);
            end
            vectors++;
            if ({out_valid, out_op, out_rd, out_writes_rd, out_a, out_b} !== {1'b1, ea.op, ea.rd, ea.wr, ea.a, ea.b}) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: got v=%b op=%h a=%h b=%h, required v=1 op=%h a=%h b=%h",
                         i, out_valid, out_op, out_a, out_b, ea.op, ea.a, ea.b);
            end
            next_cycle();
        end
        out_ready = 1'b1;
        @(negedge clk);
        eb = model_out();
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++; $display("FAIL bp_release: in_ready=%b, required 1", in_ready);
        end
        next_cycle();
        sb.push_back(eb);
        set_instr(1'b1, 6'h43, 3'd5, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        ec = model_out();
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_issue: in_ready=%b out_valid=%b, required 1 and 1", in_ready, out_valid);
        end
        next_cycle();
        sb.push_back(ec);
        set_instr(1'b0, 6'h00, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || stall_count !== 16'd5) begin
            miscompares++;
            $display("FAIL b2b_tail: out_valid=%b stall=%0d, required 1 and 5", out_valid, stall_count);
        end
        next_cycle();
    endtask

    task automatic test_reset_midflight();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            set_instr(1'b1, 6'h50 + 6'(i), 3'd6, 3'd7, (i == 0) ? 3'd0 : 3'(i + 1), 1'b0, 1'b0, 1'b1);
            @(negedge clk);
            e = model_out();
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++; $display("FAIL mid_fill[%0d]: in_ready=%b, required 1", i, in_ready);
            end
            next_cycle();
            sb.push_back(e);
        end
        set_instr(1'b0, 6'h00, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || stall_count !== 16'd5) begin
            miscompares++;
            $display("FAIL mid_pre: out_valid=%b stall=%0d, required 1 and 5", out_valid, stall_count);
        end
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        out_ready = 1'b1;
        sb.delete();
        set_instr(1'b1, 6'h5A, 3'd0, 3'd4, 3'd3, 1'b1, 1'b1, 1'b1);
        wb_drive(1'b1, 3'd2, 32'h2222_2222);
        @(negedge clk);
        e = model_out();
        vectors++;
        if ({out_valid, out_a, out_b, stall_count} !== '0) begin
            miscompares++;
            $display("FAIL mid_reset_state: v=%b a=%h b=%h stall=%0d, required all zero",
                     out_valid, out_a, out_b, stall_count);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++; $display("FAIL mid_reset_busy: in_ready=%b, required 1", in_ready);
        end
        next_cycle();
        sb.push_back(e);
        wb_drive(1'b0, 3'd0, 32'd0);
        set_instr(1'b0, 6'h00, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_saturation();
        exp_t e;
        set_instr(1'b1, 6'h60, 3'd3, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0);
        repeat (65534) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (stall_count !== 16'hFFFE || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_edge: stall=%h in_ready=%b, required FFFE and 0", stall_count, in_ready);
        end
        repeat (70000 - 65534) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (stall_count !== 16'hFFFF) begin
            miscompares++; $display("FAIL sat_hold: stall=%h, required FFFF", stall_count);
        end
        next_cycle();
        wb_drive(1'b1, 3'd3, 32'h3333_0003);
        @(negedge clk);
        e = model_out();
        vectors++;
        if (in_ready !== 1'b1 || stall_count !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL sat_release: in_ready=%b stall=%h, required 1 and FFFF", in_ready, stall_count);
        end
        next_cycle();
        sb.push_back(e);
        wb_drive(1'b0, 3'd0, 32'd0);
        set_instr(1'b0, 6'h00, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) next_cycle();
        @(negedge clk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++; $display("FAIL sb_drain: %0d entries left, required 0", sb.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b0;
        set_instr(1'b0, 6'h00, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        wb_drive(1'b0, 3'd0, 32'd0);
        test_reset();
        test_basic();
        test_raw_forward();
        test_waw();
        test_back_to_back();
        test_reset_midflight();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/scalar_operand_fetch.md
# scalar_operand_fetch

Operand-fetch stage of the scalar pipeline, directly upstream of the 8 x 32-bit scalar register bank's read ports and downstream of decode. It drives the register bank read addresses, captures the operands into a one-entry valid/ready pipeline register for execute, and keeps a per-register busy scoreboard. It stalls on RAW/WAW hazards and forwards same-cycle writeback data.

## Interface
- DATA_W, 32, operand/data width
- NREG, 8, number of scalar registers
- ADDR_W, 3, register address width (log2 NREG)

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts instruction this cycle
- in_op  in  6  opcode, passed through
- in_rs1, in_rs2, in_rd  in  ADDR_W  source/destination register indices
- in_use_rs1, in_use_rs2  in  1  instruction reads rs1/rs2
- in_writes_rd  in  1  instruction will write rd
- rf_rs1, rf_rs2  out  ADDR_W  register bank read addresses (= in_rs1/in_rs2, combinational)
- rf_ro1, rf_ro2  in  DATA_W  register bank read data (combinational)
- wb_valid  in  1  writeback this cycle (same signal that drives bank write_enable)
- wb_rd  in  ADDR_W  writeback register
- wb_data  in  DATA_W  writeback data
- out_valid  out  1  operands valid for execute
- out_ready  in  1  execute accepts
- out_op  out  6  registered opcode
- out_rd  out  ADDR_W  registered rd
- out_writes_rd  out  1  registered write flag
- out_a, out_b  out  DATA_W  registered operands
- stall_count  out  16  saturating count of hazard-stall cycles

## Operation
- Scoreboard busy[NREG-1:0]. Bit set when an instruction with in_writes_rd is accepted. Bit cleared when wb_valid with wb_rd.
- Set and clear of the same register in the same cycle: set wins, because the new writer is now in flight.
- fwd1 = wb_valid && wb_rd==in_rs1. fwd2 = wb_valid && wb_rd==in_rs2. fwd_d = wb_valid && wb_rd==in_rd.
- Hazards:
  - raw1 = in_use_rs1 && busy[in_rs1] && !fwd1
  - raw2 = in_use_rs2 && busy[in_rs2] && !fwd2
  - waw = in_writes_rd && busy[in_rd] && !fwd_d
- hazard = raw1 || raw2 || waw.
- in_ready = (!out_valid || out_ready) && !hazard. It does not depend on in_valid.
- Accept = in_valid && in_ready. On accept, load the output register:
  - out_a = fwd1 ? wb_data : rf_ro1
  - out_b = fwd2 ? wb_data : rf_ro2
  - op, rd, writes_rd are copied as given.
  - Operands of unused sources are still loaded (don't-care values).
- Output register behaviour:
  - out_valid set on accept.
  - out_valid cleared when out_ready && out_valid && no accept.
  - Output fields hold while out_valid && !out_ready.
- stall_count increments each cycle in_valid && hazard; it saturates at 16'hFFFF.
- No hardwired-zero register. Register 0 is tracked like any other register.

## Timing
- Reset values: out_valid=0, out_op=0, out_rd=0, out_writes_rd=0, out_a=0, out_b=0, busy=0, stall_count=0.
- in_ready is combinational during reset. With out_valid=0 and busy=0 it is 1, but no accept is registered while rst=1.
- rst asserted mid-operation: all state returns to reset values on that edge, including in-flight busy bits. Writebacks arriving afterwards have no scoreboard effect (clearing an already-clear bit).
- Latency: accept at edge N gives out_valid=1 after edge N. Back-to-back throughput is 1 instruction/cycle while out_ready=1 and no hazards.
- Dependent instruction:
  - It is accepted in the same cycle its producer's wb_valid is high, using wb_data.
  - One cycle earlier it stalls.
  - One cycle later it reads the bank directly, because the bank is written on the wb edge.
- Backpressure: out_ready=0 with out_valid=1 forces in_ready=0. The scoreboard still clears on wb.
- Simultaneous wb clear and new issue of the same rd: busy stays 1.

## Test plan
- Reset, then bank holds r2=5, r3=7. Issue op with rs1=2, rs2=3, rd=4, writes_rd, with out_ready=1. Required: out_a=5, out_b=7, out_valid=1 one cycle later, busy[4]=1.
- RAW with forwarding: r4 busy, next instr reads rs1=4; hold wb 3 cycles. Required: in_ready=0 for 3 cycles and stall_count=3. In the wb cycle (wb_rd=4, wb_data=0xDEADBEEF) the instruction is accepted with out_a=0xDEADBEEF.
- WAW: r1 busy, instr with rd=1 stalls until wb_rd=1. On that cycle it is accepted and busy[1] remains 1.
- Backpressure: out_ready=0 for 4 cycles with out_valid=1. Required: out fields stable, in_ready=0. Then out_ready=1 with a new instr valid gives back-to-back transfer with out_valid staying 1.
- Reset mid-flight: busy=8'h1F and out_valid=1, assert rst one cycle. Required: out_valid=0, busy=0, stall_count=0. A subsequent instr reading r0 is accepted immediately.
- Saturation: force 70000 hazard cycles. Required: stall_count=16'hFFFF and no wrap.
